// File: rtl/branch_pkg.sv
// Shared widths and the pipeline payload record for branch resolution.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_pkg;

    localparam int unsigned BR_PC_W  = 32;
    localparam int unsigned BR_POS_W = 3;
    localparam int unsigned BR_CNT_W = 32;

    // Everything that travels with an instruction from IF to EX.
    typedef struct packed {
        logic                valid;
        logic [BR_PC_W-1:0]  pc;
        logic [BR_PC_W-1:0]  pc_pre;
        logic                hit;
        logic [BR_POS_W-1:0] hitpos;
    } stage_t;

endpackage

// File: rtl/pred_stage_reg.sv
// One pipeline register holding the prediction payload of a single instruction.
// Latency: 1 cycle from d to q when load is high.
// Backpressure: load low holds the contents; clear kills the entry (valid only).
module pred_stage_reg
    import branch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   clear,
    input  stage_t d,
    output stage_t q
);

    stage_t r_q;

    // Reset wins, then a redirect kill, then a normal advance; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clear) begin
            r_q.valid <= 1'b0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/branch_resolve.sv
// Carries predictions IF->ID->EX, checks them against the resolved next PC, redirects and counts.
// Latency: instruction accepted in IF at cycle n is resolved combinationally at cycle n+2.
// Backpressure: stall freezes both stages and suppresses update/flush until released.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned PC_W  = BR_PC_W,
    parameter int unsigned POS_W = BR_POS_W,
    parameter int unsigned CNT_W = BR_CNT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [PC_W-1:0]  if_pc_pre,
    input  logic             if_hit,
    input  logic [POS_W-1:0] if_hitpos,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic [PC_W-1:0]  pc_ex,
    output logic [PC_W-1:0]  pc_npc,
    output logic             hit_ex,
    output logic [POS_W-1:0] hitpos_ex,
    output logic             preright_ex,
    output logic             branch_ex,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           w_if_stage;
    stage_t           w_id_stage;
    stage_t           w_ex_stage;
    logic [PC_W-1:0]  w_pc_npc;
    logic             w_preright;
    logic             w_ex_fire;
    logic             w_branch;
    logic             w_flush;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    assign w_if_stage = '{valid: if_valid, pc: if_pc, pc_pre: if_pc_pre,
                          hit: if_hit, hitpos: if_hitpos};

    pred_stage_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (~stall),
        .clear (w_flush),
        .d     (w_if_stage),
        .q     (w_id_stage)
    );

    pred_stage_reg u_id_ex (
        .clk   (clk),
        .rst   (rst),
        .load  (~stall),
        .clear (w_flush),
        .d     (w_id_stage),
        .q     (w_ex_stage)
    );

    // Actual next PC: taken branches go to the ALU target, everything else falls through (wraps).
    assign w_pc_npc    = (ex_taken & ex_is_branch) ? ex_target : w_ex_stage.pc + PC_ONE;
    assign w_preright  = (w_ex_stage.pc_pre == w_pc_npc);

    // An EX instruction only takes effect when real, not held, and not being reset;
    // a stalled mispredict simply waits here until the stall drops.
    assign w_ex_fire   = w_ex_stage.valid & ~stall & ~rst;
    assign w_branch    = w_ex_fire & ex_is_branch;
    // Any wrong next-PC guess redirects, including a stale hit on a non-branch.
    assign w_flush     = w_ex_fire & ~w_preright;

    assign pc_ex       = w_ex_stage.pc;
    assign pc_npc      = w_pc_npc;
    assign hit_ex      = w_ex_stage.hit;
    assign hitpos_ex   = w_ex_stage.hitpos;
    assign preright_ex = w_preright;
    assign branch_ex   = w_branch;
    assign flush       = w_flush;
    assign redirect_pc = w_flush ? w_pc_npc : '0;

    // Saturating statistics: resolved branches and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_branch && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_flush && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic against a reference model.
// Latency: model tracks the two in-flight slots and predicts outputs each cycle.
// Backpressure: random stall and reset are part of the stimulus.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst, stall, if_valid, if_hit, ex_is_branch, ex_taken;
    logic [31:0] if_pc, if_pc_pre, ex_target;
    logic [2:0]  if_hitpos;
    logic [31:0] pc_ex, pc_npc, redirect_pc, branch_cnt, mispred_cnt;
    logic        hit_ex, preright_ex, branch_ex, flush;
    logic [2:0]  hitpos_ex;

    branch_resolve dut (
        .clk(clk), .rst(rst), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_pre(if_pc_pre),
        .if_hit(if_hit), .if_hitpos(if_hitpos),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_ex(pc_ex), .pc_npc(pc_npc), .hit_ex(hit_ex), .hitpos_ex(hitpos_ex),
        .preright_ex(preright_ex), .branch_ex(branch_ex), .flush(flush),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: contents of the ID and EX slots plus the two statistics.
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pre;
        logic        hit;
        logic [2:0]  pos;
    } slot_t;

    slot_t       m_id, m_ex;
    logic [31:0] m_bcnt, m_mcnt;

    task automatic model_reset();
        m_id   = '{v: 1'b0, pc: 32'd0, pre: 32'd0, hit: 1'b0, pos: 3'd0};
        m_ex   = m_id;
        m_bcnt = 32'd0;
        m_mcnt = 32'd0;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] pre,
                          input logic hit, input logic [2:0] pos);
        if_valid = v; if_pc = pc; if_pc_pre = pre; if_hit = hit; if_hitpos = pos;
    endtask

    task automatic set_ex(input logic isb, input logic tk, input logic [31:0] tgt);
        ex_is_branch = isb; ex_taken = tk; ex_target = tgt;
    endtask

    // One clock: compare every output to the model, take the edge, advance the model.
    task automatic cyc();
        logic [31:0] npc;
        logic        e_br, e_fl;
        #1;
        npc  = (ex_taken && ex_is_branch) ? ex_target : m_ex.pc + 32'd1;
        e_br = !rst && m_ex.v && !stall && ex_is_branch;
        e_fl = !rst && m_ex.v && !stall && (m_ex.pre != npc);
        chk("pc_ex",       pc_ex,       m_ex.pc);
        chk("pc_npc",      pc_npc,      npc);
        chk("hit_ex",      hit_ex,      m_ex.hit);
        chk("hitpos_ex",   hitpos_ex,   m_ex.pos);
        chk("preright_ex", preright_ex, m_ex.pre == npc);
        chk("branch_ex",   branch_ex,   e_br);
        chk("flush",       flush,       e_fl);
        chk("redirect_pc", redirect_pc, e_fl ? npc : 32'd0);
        chk("branch_cnt",  branch_cnt,  m_bcnt);
        chk("mispred_cnt", mispred_cnt, m_mcnt);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_br && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (e_fl && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
            if (e_fl) begin
                m_id.v = 1'b0;
                m_ex.v = 1'b0;
            end else if (!stall) begin
                m_ex = m_id;
                m_id = '{v: if_valid, pc: if_pc, pre: if_pc_pre, hit: if_hit, pos: if_hitpos};
            end
        end
        @(negedge clk);
    endtask

    // Put one instruction in IF and walk it into EX (IF empty behind it).
    task automatic to_ex(input logic [31:0] pc, input logic [31:0] pre,
                         input logic hit, input logic [2:0] pos);
        set_if(1'b1, pc, pre, hit, pos); set_ex(1'b0, 1'b0, 32'd0); cyc();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0); cyc();
    endtask

    initial begin
        model_reset();
        rst = 1'b1; stall = 1'b0;
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        set_ex(1'b0, 1'b0, 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Reset state
        #1;
        chk("rst_pc_ex",   pc_ex,       32'd0);
        chk("rst_pc_npc",  pc_npc,      32'd1);
        chk("rst_flush",   flush,       1'b0);
        chk("rst_branch",  branch_ex,   1'b0);
        chk("rst_redir",   redirect_pc, 32'd0);
        chk("rst_bcnt",    branch_cnt,  32'd0);
        chk("rst_mcnt",    mispred_cnt, 32'd0);
        cyc();
        rst = 1'b0;

        // Correctly predicted taken branch
        to_ex(32'h10, 32'h20, 1'b1, 3'd5);
        set_ex(1'b1, 1'b1, 32'h20);
        #1;
        chk("d41_branch",   branch_ex,   1'b1);
        chk("d41_preright", preright_ex, 1'b1);
        chk("d41_hitpos",   hitpos_ex,   3'd5);
        chk("d41_flush",    flush,       1'b0);
        cyc();
        set_ex(1'b0, 1'b0, 32'd0);
        #1 chk("d41_bcnt", branch_cnt, 32'd1);
        cyc();

        // Mispredicted branch with younger work in ID and IF being discarded
        set_if(1'b1, 32'h10, 32'h11, 1'b0, 3'd0); cyc();
        set_if(1'b1, 32'h80, 32'h81, 1'b0, 3'd0); cyc();
        set_if(1'b1, 32'h90, 32'h91, 1'b0, 3'd0);
        set_ex(1'b1, 1'b1, 32'h40);
        #1;
        chk("d42_flush",    flush,       1'b1);
        chk("d42_redir",    redirect_pc, 32'h40);
        chk("d42_npc",      pc_npc,      32'h40);
        chk("d42_preright", preright_ex, 1'b0);
        cyc();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        set_ex(1'b1, 1'b1, 32'h77);
        #1;
        chk("d42_kill_flush",  flush,       1'b0);
        chk("d42_kill_branch", branch_ex,   1'b0);
        chk("d42_mcnt",        mispred_cnt, 32'd1);
        cyc();
        #1 chk("d42_id_killed", branch_ex, 1'b0);
        cyc();

        // Stale hit on a non-branch
        to_ex(32'h30, 32'h50, 1'b1, 3'd2);
        set_ex(1'b0, 1'b0, 32'd0);
        #1;
        chk("d43_flush",  flush,       1'b1);
        chk("d43_redir",  redirect_pc, 32'h31);
        chk("d43_branch", branch_ex,   1'b0);
        cyc();
        #1 chk("d43_bcnt", branch_cnt, 32'd2);
        cyc();

        // Mispredicting branch held by a 3-cycle stall
        to_ex(32'h60, 32'h61, 1'b0, 3'd0);
        set_ex(1'b1, 1'b1, 32'h70);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("d44_stall_flush",  flush,     1'b0);
            chk("d44_stall_branch", branch_ex, 1'b0);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("d44_rel_flush",  flush,     1'b1);
        chk("d44_rel_branch", branch_ex, 1'b1);
        cyc();
        set_ex(1'b0, 1'b0, 32'd0);
        #1;
        chk("d44_one_flush", flush,       1'b0);
        chk("d44_bcnt",      branch_cnt,  32'd3);
        chk("d44_mcnt",      mispred_cnt, 32'd3);
        cyc();

        // PC wrap on a not-taken branch
        to_ex(32'hFFFF_FFFF, 32'h0, 1'b1, 3'd7);
        set_ex(1'b1, 1'b0, 32'h123);
        #1;
        chk("d45_npc",      pc_npc,      32'h0);
        chk("d45_preright", preright_ex, 1'b1);
        chk("d45_flush",    flush,       1'b0);
        cyc();

        // Reset arriving while a mispredicting branch sits in EX
        to_ex(32'h100, 32'h101, 1'b0, 3'd0);
        set_ex(1'b1, 1'b1, 32'h200);
        rst = 1'b1;
        #1;
        chk("d46_flush",  flush,     1'b0);
        chk("d46_branch", branch_ex, 1'b0);
        cyc();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 32'd0);
        #1;
        chk("d46_flush_after", flush,       1'b0);
        chk("d46_bcnt",        branch_cnt,  32'd0);
        chk("d46_mcnt",        mispred_cnt, 32'd0);
        cyc();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 4) == 0);
            pc    = 32'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0:       set_if($urandom_range(0, 9) < 7, pc, pc + 32'd1, 1'($urandom), 3'($urandom));
                1:       set_if($urandom_range(0, 9) < 7, pc, 32'h100, 1'($urandom), 3'($urandom));
                default: set_if($urandom_range(0, 9) < 7, pc, 32'h200, 1'($urandom), 3'($urandom));
            endcase
            set_ex(1'($urandom), 1'($urandom), $urandom_range(0, 1) ? 32'h100 : 32'h200);
            cyc();
        end
        rst = 1'b0; stall = 1'b0;
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        set_ex(1'b0, 1'b0, 32'd0);
        cyc(); cyc(); cyc();

        // Saturation: preload the redirect counter, then mispredict once more
        force dut.r_mispred_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_mispred_cnt;
        m_mcnt = 32'hFFFF_FFFF;
        to_ex(32'h40, 32'h41, 1'b0, 3'd0);
        set_ex(1'b1, 1'b1, 32'h99);
        #1 chk("d45_sat_flush", flush, 1'b1);
        cyc();
        set_ex(1'b0, 1'b0, 32'd0);
        #1 chk("d45_sat_mcnt", mispred_cnt, 32'hFFFF_FFFF);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
